// File: rtl/lvds_rx_word_aligner.sv
// lvds_rx_word_aligner
//   Word aligner for one LVDS deserializer, running in its rx_outclock domain.
//   Bitslips the deserializer until the frame-clock lane carries FRAME_PATTERN,
//   then registers the data lanes and keeps watching the frame word for loss of
//   alignment.
// Ports
//   rx_clk        deserializer rx_outclock (only clock)
//   reset         asynchronous, active-high
//   rx_locked     deserializer PLL lock
//   rx_out        lane i at [i*DESER +: DESER]; frame-clock lane is lane NR_LANES
//   realign       single-cycle pulse forcing re-acquisition
//   rx_data_align registered bitslip request, high only while slipping
//   data_out      registered data lanes (1-cycle latency)
//   data_valid    data_out holds aligned sample data
//   aligned       alignment state reached
//   align_fail    sticky: 2*DESER slips in one attempt without aligning
//   slip_count    slips since reset, saturating at 255
module lvds_rx_word_aligner #(
  parameter int unsigned            NR_LANES      = 8,
  parameter int unsigned            DESER         = 6,
  parameter logic [DESER-1:0]       FRAME_PATTERN = 6'b111000,
  parameter int unsigned            SLIP_CYCLES   = 2,
  parameter int unsigned            SETTLE_CYCLES = 8,
  parameter int unsigned            LOCK_COUNT    = 16,
  parameter int unsigned            UNLOCK_ERRORS = 4
) (
  input  logic                            rx_clk,
  input  logic                            reset,
  input  logic                            rx_locked,
  input  logic [(NR_LANES+1)*DESER-1:0]   rx_out,
  input  logic                            realign,
  output logic                            rx_data_align,
  output logic [NR_LANES*DESER-1:0]       data_out,
  output logic                            data_valid,
  output logic                            aligned,
  output logic                            align_fail,
  output logic [7:0]                      slip_count
);

  localparam int unsigned TMAX       = (SLIP_CYCLES > SETTLE_CYCLES) ? SLIP_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TW         = $clog2(TMAX + 1);
  localparam int unsigned MW         = $clog2(LOCK_COUNT + 1);
  localparam int unsigned EW         = $clog2(UNLOCK_ERRORS + 1);
  localparam int unsigned FAIL_SLIPS = 2 * DESER;
  localparam int unsigned AW         = $clog2(FAIL_SLIPS + 1);

  localparam logic [TW-1:0] SLIP_LAST   = TW'(SLIP_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [MW-1:0] MATCH_DONE  = MW'(LOCK_COUNT);
  localparam logic [EW-1:0] ERR_LIMIT   = EW'(UNLOCK_ERRORS);
  localparam logic [AW-1:0] ATT_MAX     = AW'(FAIL_SLIPS);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    CHECK,
    SLIP,
    SETTLE,
    LOCKED
  } state_t;

  state_t          state, state_n;
  logic [MW-1:0]   match_cnt, match_n;
  logic [EW-1:0]   err_cnt, err_n;
  logic [TW-1:0]   tmr, tmr_n;
  logic [AW-1:0]   att, att_n;
  logic [7:0]      slips_n;
  logic            fail_n;
  logic            fw_match;

  assign fw_match = (rx_out[NR_LANES*DESER +: DESER] == FRAME_PATTERN);

  always_comb begin
    state_n = state;
    match_n = match_cnt;
    err_n   = err_cnt;
    tmr_n   = tmr;
    att_n   = att;
    slips_n = slip_count;
    fail_n  = align_fail;

    if (!rx_locked) begin
      state_n = WAIT_LOCK;
      match_n = '0;
      err_n   = '0;
      att_n   = '0;
    end else if (realign && (state != WAIT_LOCK)) begin
      state_n = CHECK;
      match_n = '0;
      err_n   = '0;
      att_n   = '0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          state_n = CHECK;
          match_n = '0;
        end
        CHECK: begin
          // The lock decision is taken on the cycle after the LOCK_COUNT-th
          // matching word has been counted.
          if (match_cnt == MATCH_DONE) begin
            state_n = LOCKED;
            err_n   = '0;
            att_n   = '0;
          end else if (fw_match) begin
            match_n = match_cnt + 1'b1;
          end else begin
            state_n = SLIP;
            match_n = '0;
            tmr_n   = '0;
            if (slip_count != 8'hFF) slips_n = slip_count + 8'd1;
            if (att != ATT_MAX) att_n = att + 1'b1;
            if (att_n == ATT_MAX) fail_n = 1'b1;
          end
        end
        SLIP: begin
          if (tmr == SLIP_LAST) begin
            state_n = SETTLE;
            tmr_n   = '0;
          end else begin
            tmr_n = tmr + 1'b1;
          end
        end
        SETTLE: begin
          if (tmr == SETTLE_LAST) begin
            state_n = CHECK;
            match_n = '0;
            tmr_n   = '0;
          end else begin
            tmr_n = tmr + 1'b1;
          end
        end
        LOCKED: begin
          if (fw_match) begin
            err_n = '0;
          end else if ((err_cnt + 1'b1) == ERR_LIMIT) begin
            state_n = CHECK;
            err_n   = '0;
            match_n = '0;
          end else begin
            err_n = err_cnt + 1'b1;
          end
        end
        default: state_n = WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      state         <= WAIT_LOCK;
      match_cnt     <= '0;
      err_cnt       <= '0;
      tmr           <= '0;
      att           <= '0;
      slip_count    <= '0;
      align_fail    <= 1'b0;
      rx_data_align <= 1'b0;
      aligned       <= 1'b0;
      data_valid    <= 1'b0;
      data_out      <= '0;
    end else begin
      state         <= state_n;
      match_cnt     <= match_n;
      err_cnt       <= err_n;
      tmr           <= tmr_n;
      att           <= att_n;
      slip_count    <= slips_n;
      align_fail    <= fail_n;
      // Outputs decoded from the next state so they line up with the state register.
      rx_data_align <= (state_n == SLIP);
      aligned       <= (state_n == LOCKED);
      data_valid    <= (state == LOCKED) && fw_match && rx_locked;
      data_out      <= rx_out[NR_LANES*DESER-1:0];
    end
  end

endmodule
